// File: rtl/uart_cmd_dispatch.sv
// rtl/uart_cmd_dispatch.sv - decodes validated 12-byte UART frames into one or two config-bus writes
module uart_cmd_dispatch #(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  rev_data0,
  input  logic [7:0]  rev_data1,
  input  logic [7:0]  rev_data2,
  input  logic [7:0]  rev_data3,
  input  logic [7:0]  rev_data4,
  input  logic [7:0]  rev_data5,
  input  logic [7:0]  rev_data6,
  input  logic [7:0]  rev_data7,
  input  logic [7:0]  rev_data8,
  input  logic [7:0]  rev_data9,
  input  logic [7:0]  rev_data10,
  input  logic [7:0]  rev_data11,
  output logic        cfg_wr_req,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wdata,
  input  logic        cfg_ack,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {IDLE, CHECK, WR0, GAP, WR1, DONE, ERR} state_t;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t        state, state_nx;
  logic [7:0]    rev [12];
  logic [7:0]    b [12];
  logic [7:0]    csum;
  logic [TW-1:0] wait_cnt;
  logic          last_wait;
  logic          code_ld;
  logic [1:0]    code_nx;

  assign rev = '{rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
                 rev_data6, rev_data7, rev_data8, rev_data9, rev_data10, rev_data11};

  // Reserved byte b10 takes part in the checksum only.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 11; i++) csum = csum ^ b[i];
  end

  assign last_wait  = (wait_cnt == TW'(ACK_TIMEOUT - 1));
  assign cfg_wr_req = (state == WR0) || (state == WR1);
  assign busy       = (state != IDLE);
  assign cmd_done   = (state == DONE);
  assign cmd_err    = (state == ERR);

  always_comb begin
    state_nx = state;
    code_ld  = 1'b0;
    code_nx  = err_code;
    case (state)
      IDLE:  if (recv_done) state_nx = CHECK;
      CHECK: begin
        code_ld = 1'b1;
        if (csum != b[11]) begin
          state_nx = ERR;
          code_nx  = 2'd1;
        end else if (b[0] != 8'h01 && b[0] != 8'h02 && b[0] != 8'h03) begin
          state_nx = ERR;
          code_nx  = 2'd2;
        end else begin
          state_nx = WR0;
          code_nx  = 2'd0;
        end
      end
      WR0: begin
        if (cfg_ack) begin
          state_nx = (b[0] == 8'h01) ? GAP : DONE;
        end else if (last_wait) begin
          state_nx = ERR;
          code_ld  = 1'b1;
          code_nx  = 2'd3;
        end
      end
      GAP:   state_nx = WR1;
      WR1: begin
        if (cfg_ack) begin
          state_nx = DONE;
        end else if (last_wait) begin
          state_nx = ERR;
          code_ld  = 1'b1;
          code_nx  = 2'd3;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      for (int i = 0; i < 12; i++) b[i] <= 8'h00;
      wait_cnt  <= '0;
      cfg_addr  <= 8'h00;
      cfg_wdata <= 32'h0;
      err_code  <= 2'd0;
      ok_cnt    <= 16'h0;
      err_cnt   <= 8'h00;
      drop_cnt  <= 8'h00;
    end else begin
      if (state == IDLE && recv_done) begin
        for (int i = 0; i < 12; i++) b[i] <= rev[i];
      end
      // Counts consecutive request cycles; any low cycle restarts the window.
      if (cfg_wr_req) wait_cnt <= wait_cnt + 1'b1;
      else            wait_cnt <= '0;
      if (state == CHECK && state_nx == WR0) begin
        case (b[0])
          8'h01: begin
            cfg_addr  <= b[1];
            cfg_wdata <= {b[2], b[3], b[4], b[5]};
          end
          8'h02: begin
            cfg_addr  <= 8'hF0;
            cfg_wdata <= {24'h0, b[1]};
          end
          default: begin
            cfg_addr  <= 8'hF0;
            cfg_wdata <= 32'h0;
          end
        endcase
      end else if (state == GAP) begin
        cfg_addr  <= b[1] + 8'd1;
        cfg_wdata <= {b[6], b[7], b[8], b[9]};
      end
      if (code_ld) err_code <= code_nx;
      if (state == DONE) ok_cnt <= ok_cnt + 16'd1;
      if (state == ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (recv_done && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb/tb_uart_cmd_dispatch.sv - scoreboard bench for uart_cmd_dispatch
module tb_uart_cmd_dispatch;

  localparam int TO = 1024;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        recv_done;
  logic [7:0]  rd [12];
  logic        cfg_wr_req;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ack;
  logic        busy, cmd_done, cmd_err;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt;
  logic [7:0]  err_cnt, drop_cnt;

  uart_cmd_dispatch #(.ACK_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .recv_done(recv_done),
    .rev_data0(rd[0]), .rev_data1(rd[1]), .rev_data2(rd[2]), .rev_data3(rd[3]),
    .rev_data4(rd[4]), .rev_data5(rd[5]), .rev_data6(rd[6]), .rev_data7(rd[7]),
    .rev_data8(rd[8]), .rev_data9(rd[9]), .rev_data10(rd[10]), .rev_data11(rd[11]),
    .cfg_wr_req(cfg_wr_req), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .err_code(err_code),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 error
    logic [7:0]  addr;
    logic [31:0] data;
    int          gap;    // cycles since previous accepted write, 0 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          last_run = 0;
  int          cyc = 0;
  logic [15:0] ok_m = 0;
  int          err_m = 0;
  int          drop_m = 0;
  int          code_m = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push(input int k, input int a, input logic [31:0] d, input int g);
    exp_t e;
    e.kind = k; e.addr = a[7:0]; e.data = d; e.gap = g;
    exp_q.push_back(e);
  endfunction

  function automatic void push_err(input int c);
    push(2, 0, c, 0);
    if (err_m < 255) err_m++;
    code_m = c;
  endfunction

  // Reference: frame rules evaluated directly from byte values.
  function automatic void model_frame(input logic [7:0] f [12], input int d);
    int x = 0;
    int cmd = f[0];
    for (int i = 0; i < 11; i++) x = x ^ int'(f[i]);
    if (x != int'(f[11]))                       push_err(1);
    else if (cmd < 1 || cmd > 3)                push_err(2);
    else if (d < 0 || d >= TO)                  push_err(3);
    else begin
      if (cmd == 1) begin
        push(0, f[1], {f[2], f[3], f[4], f[5]}, 0);
        push(0, (int'(f[1]) + 1) % 256, {f[6], f[7], f[8], f[9]}, d + 2);
      end else if (cmd == 2) begin
        push(0, 'hF0, 32'(f[1]), 0);
      end else begin
        push(0, 'hF0, 0, 0);
      end
      push(1, 0, 0, 0);
      ok_m   = ok_m + 16'd1;
      code_m = 0;
    end
  endfunction

  // Ack responder: acks the (ack_delay+1)-th cycle of each request, never if negative.
  initial begin
    int rc = 0;
    cfg_ack = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (cfg_wr_req) begin
        cfg_ack = (ack_delay >= 0 && rc == ack_delay);
        rc++;
      end else begin
        if (rc != 0) last_run = rc;
        rc = 0;
        cfg_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    int last_acc = 0;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst_n && (cmd_done || cmd_err || (cfg_wr_req && cfg_ack))) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {61'h0, cmd_err, cmd_done, cfg_ack}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          if (cfg_wr_req && cfg_ack) begin
            chk("write_kind", 64'(cmd_done), 64'(0));
            chk("event_kind", 0, 64'(e.kind));
            chk("write_addr", cfg_addr, e.addr);
            chk("write_data", cfg_wdata, e.data);
            if (e.gap != 0) chk("write_gap", 64'(cyc - last_acc), 64'(e.gap));
            last_acc = cyc;
          end else if (cmd_done) begin
            chk("event_kind", 1, 64'(e.kind));
            chk("done_code", err_code, 0);
          end else begin
            chk("event_kind", 2, 64'(e.kind));
            chk("err_code", err_code, e.data);
            if (e.data == 3) chk("timeout_req_cycles", 64'(last_run), 64'(TO));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] f [12]);
    @(negedge sys_clk);
    rd = f;
    recv_done = 1'b1;
    @(negedge sys_clk);
    recv_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_counts(input string tag);
    @(negedge sys_clk);
    chk({tag, "_ok_cnt"}, ok_cnt, ok_m);
    chk({tag, "_err_cnt"}, err_cnt, 64'(err_m));
    chk({tag, "_drop_cnt"}, drop_cnt, 64'(drop_m));
    chk({tag, "_err_code"}, err_code, 64'(code_m));
    chk({tag, "_req_low"}, cfg_wr_req, 0);
  endtask

  task automatic run_frame(input logic [7:0] f [12], input int d, input string tag);
    ack_delay = d;
    model_frame(f, d);
    send(f);
    wait_idle();
    check_counts(tag);
  endtask

  function automatic void fix_sum(inout logic [7:0] f [12]);
    logic [7:0] x = 0;
    for (int i = 0; i < 11; i++) x = x ^ f[i];
    f[11] = x;
  endfunction

  initial begin
    logic [7:0] f [12];
    logic [7:0] g [12];
    int n;
    recv_done = 1'b0;
    for (int i = 0; i < 12; i++) rd[i] = 8'h00;
    sys_rst_n = 1'b1;
    #1;
    chk("rst_req", cfg_wr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", ok_cnt, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;

    // Two-write command with latency checks on busy and request.
    f = '{8'h01, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h11};
    ack_delay = 3;
    model_frame(f, 3);
    send(f);
    chk("busy_T1", busy, 1);
    chk("req_T1", cfg_wr_req, 0);
    @(negedge sys_clk);
    chk("req_T2", cfg_wr_req, 1);
    wait_idle();
    check_counts("cmd01");

    f[11] = 8'h12;
    run_frame(f, 3, "bad_sum");

    f = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    run_frame(f, 0, "cmd02");
    f = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    run_frame(f, 1, "cmd03");
    f = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    run_frame(f, 1, "bad_cmd");

    // Ack on the last allowed cycle still succeeds; no ack at all times out.
    f = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h56};
    run_frame(f, TO - 1, "late_ack");
    f = '{8'h01, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h11};
    run_frame(f, -1, "timeout");

    // Second frame during WR0 is dropped; address wraps FFh -> 00h.
    f = '{8'h01, 8'hFF, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00, 8'h00};
    fix_sum(f);
    ack_delay = 3;
    model_frame(f, 3);
    send(f);
    n = 0;
    while (!cfg_wr_req && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drop_saw_req", cfg_wr_req, 1);
    g = '{8'h02, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h46};
    send(g);
    drop_m++;
    wait_idle();
    check_counts("drop");

    // Randomised frames.
    for (int k = 0; k < 60; k++) begin
      int r = $urandom_range(0, 9);
      for (int i = 0; i < 11; i++) f[i] = 8'($urandom);
      f[0] = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : (r < 6) ? 8'h03 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) f[1] = 8'hFF;
      fix_sum(f);
      if ($urandom_range(0, 5) == 0) f[11] = f[11] ^ 8'($urandom_range(1, 255));
      run_frame(f, $urandom_range(0, 6), "rand");
    end

    // Reset while a request is waiting for ack.
    f = '{8'h01, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00};
    fix_sum(f);
    ack_delay = -1;
    send(f);
    repeat (4) @(negedge sys_clk);
    chk("pre_rst_req", cfg_wr_req, 1);
    sys_rst_n = 1'b1;
    #1;
    chk("mid_rst_req", cfg_wr_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ok", ok_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_addr", cfg_addr, 0);
    exp_q.delete();
    ok_m = 0; err_m = 0; drop_m = 0; code_m = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    ack_delay = 0;
    repeat (20) @(negedge sys_clk);
    check_counts("post_rst");

    // Error counter saturation.
    f = '{8'h01, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h12};
    for (int k = 0; k < 300; k++) begin
      model_frame(f, 0);
      send(f);
      wait_idle();
    end
    check_counts("err_sat");
    chk("err_sat_255", err_cnt, 255);

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
